// File: rtl/namuru_accum_reader_if.sv
// ---------------------------------------------------------------------------
// namuru_accum_reader_if
//
// Bundles the two buses of the accumulation reader:
//   - Wishbone read initiator towards the correlator register window
//     (wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o outbound,
//      wb_dat_i, wb_ack_i inbound).
//   - Tagged measurement stream towards the tracking-loop data path
//     (out_data, out_tag, out_valid, out_last, out_err outbound,
//      out_ready inbound).
//
// Modports:
//   master : the reader itself (drives the bus request and the stream).
//   slave  : the environment (correlator slave port plus stream consumer).
// ---------------------------------------------------------------------------
interface namuru_accum_reader_if;

  // Wishbone read initiator
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  // Measurement stream
  logic [31:0] out_data;
  logic [7:0]  out_tag;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_err;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_dat_i, wb_ack_i,
    output out_data, out_tag, out_valid, out_last, out_err,
    input  out_ready
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_dat_i, wb_ack_i,
    input  out_data, out_tag, out_valid, out_last, out_err,
    output out_ready
  );

endinterface

// File: rtl/namuru_accum_reader.sv
// ---------------------------------------------------------------------------
// namuru_accum_reader
//
// Wishbone read initiator that drains correlator channel 0 after every
// accumulation interrupt. Each rising edge of accum_int (while idle and
// enabled) starts a frame of single read cycles in the order
//   E0 (status), E1 (new_data), 04, 05, ... 0D (channel 0 results).
// If bit 0 of the new_data word is clear the frame stops after E1.
// Every read word is forwarded on the valid/ready stream tagged with its
// word index; out_last marks the final word of a frame.
//
// Parameters:
//   BASE_ADDR : byte base of the register window; word w -> BASE_ADDR + 4*w.
//   TIMEOUT   : REQ cycles without ack before the read is abandoned
//               (only with NAMURU_RD_TIMEOUT_EN).
//
// Build option:
//   NAMURU_RD_TIMEOUT_EN : when defined, a read that is not acknowledged
//   within TIMEOUT cycles ends the frame with a 32'hDEAD_BEEF word flagged
//   by out_err=1 and out_last=1. When undefined, REQ waits for ack forever
//   and out_err is tied low.
//
// Ports:
//   correlator_clk : single clock for all logic.
//   rstn           : asynchronous active-low reset.
//   enable         : 1 = accept triggers in IDLE; an in-flight frame always
//                    completes.
//   accum_int      : accumulation interrupt level from the correlator.
//   overrun        : sticky, set by a trigger arriving outside IDLE.
//   clr_overrun    : synchronous clear of overrun (a simultaneous set wins).
//   bus            : Wishbone initiator and measurement stream (master).
// ---------------------------------------------------------------------------
module namuru_accum_reader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                        correlator_clk,
  input  logic                        rstn,
  input  logic                        enable,
  input  logic                        accum_int,
  output logic                        overrun,
  input  logic                        clr_overrun,
  namuru_accum_reader_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    PUSH
  } state_t;

  localparam logic [3:0]  NEWDATA_IDX  = 4'd1;
  localparam logic [3:0]  LAST_IDX     = 4'd11;
  localparam logic [31:0] TIMEOUT_WORD = 32'hDEAD_BEEF;

  // The counter compares against TIMEOUT-1, so anything below 2 would
  // abandon a read before the slave could possibly answer.
  if (TIMEOUT < 2) begin : g_timeout_range
    $error("namuru_accum_reader: TIMEOUT must be at least 2");
  end

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       accum_int_q;
  logic       trigger;
  logic       capture;      // ack accepted this cycle
  logic       expired;      // read abandoned this cycle
  logic       timeout_hit;
  logic       enter_req;

  // Sequence index -> register word index: 0 -> E0, 1 -> E1, 2..11 -> 04..0D.
  function automatic logic [7:0] tag_of(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'hE0;
      4'd1:    return 8'hE1;
      default: return {4'h0, idx} + 8'd2;
    endcase
  endfunction

  assign trigger   = accum_int & ~accum_int_q;
  assign enter_req = (state_d == REQ) && (state_q != REQ);

  // Read-only initiator: write data, byte selects and direction are fixed.
  assign bus.wb_dat_o = 32'h0;
  assign bus.wb_sel_o = 4'hF;
  assign bus.wb_we_o  = 1'b0;

  // -------------------------------------------------------------------------
  // State register and sequence index
  // -------------------------------------------------------------------------
  always_ff @(posedge correlator_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      accum_int_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values and updates together.
      state_q     <= state_d;
      idx_q       <= idx_d;
      accum_int_q <= accum_int;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch
    // can leave one unassigned and infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    expired = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (trigger && enable) state_d = REQ;
      end
      REQ: begin
        if (bus.wb_ack_i) begin
          capture = 1'b1;
          state_d = PUSH;
        end else if (timeout_hit) begin
          expired = 1'b1;
          state_d = PUSH;
        end
      end
      PUSH: begin
        if (bus.out_ready) begin
          if (bus.out_last) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            state_d = REQ;
            idx_d   = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Bus request and stream registers
  // -------------------------------------------------------------------------
  always_ff @(posedge correlator_clk or negedge rstn) begin
    if (!rstn) begin
      bus.wb_cyc_o  <= 1'b0;
      bus.wb_stb_o  <= 1'b0;
      bus.wb_adr_o  <= BASE_ADDR;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 32'h0;
      bus.out_tag   <= 8'h0;
      bus.out_last  <= 1'b0;
    end else begin
      // Request follows the next state, so cyc/stb drop on the ack edge and
      // stay low for the whole PUSH phase.
      bus.wb_cyc_o  <= (state_d == REQ);
      bus.wb_stb_o  <= (state_d == REQ);
      bus.out_valid <= (state_d == PUSH);

      if (enter_req) begin
        bus.wb_adr_o <= BASE_ADDR + {22'd0, tag_of(idx_d), 2'b00};
      end

      // Stream word only changes while in REQ, so it is held for all of PUSH.
      if (capture) begin
        bus.out_data <= bus.wb_dat_i;
        bus.out_tag  <= tag_of(idx_q);
        bus.out_last <= (idx_q == LAST_IDX) ||
                        ((idx_q == NEWDATA_IDX) && !bus.wb_dat_i[0]);
      end else if (expired) begin
        bus.out_data <= TIMEOUT_WORD;
        bus.out_tag  <= tag_of(idx_q);
        bus.out_last <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Overrun: any trigger outside IDLE is dropped and remembered
  // -------------------------------------------------------------------------
  always_ff @(posedge correlator_clk or negedge rstn) begin
    if (!rstn) begin
      overrun <= 1'b0;
    end else if (trigger && (state_q != IDLE)) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Optional read timeout
  // -------------------------------------------------------------------------
`ifdef NAMURU_RD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;

  // Counts REQ cycles of the current read; restarts for every new read.
  always_ff @(posedge correlator_clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (enter_req) begin
      cnt_q <= '0;
    end else if (state_q == REQ) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge correlator_clk or negedge rstn) begin
    if (!rstn) begin
      bus.out_err <= 1'b0;
    end else if (capture) begin
      bus.out_err <= 1'b0;
    end else if (expired) begin
      bus.out_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus.out_err = 1'b0;
`endif

endmodule
